// File: rtl/ls175_quad_dff.sv
// -----------------------------------------------------------------------------
// ls175_quad_dff
//   Quadruple D-type flip-flop with common clock and common synchronous clear,
//   modelled on the SN74LS175. Four independent 1-bit stages, each with a true
//   and a complementary output derived from the same storage bit.
//
// Ports
//   _CLK              in   Clock; all state changes on the rising edge.
//   _CLR              in   Synchronous active-high clear; priority over load.
//   _1D.._4D          in   Data inputs, one per stage.
//   _1Q.._4Q          out  True outputs, one per stage.
//   _1Q_INV.._4Q_INV  out  Complement outputs, always ~_nQ.
// -----------------------------------------------------------------------------
module ls175_quad_dff (
  input  logic _CLK,
  input  logic _CLR,
  input  logic _1D,
  input  logic _2D,
  input  logic _3D,
  input  logic _4D,
  output logic _1Q,
  output logic _1Q_INV,
  output logic _2Q,
  output logic _2Q_INV,
  output logic _3Q,
  output logic _3Q_INV,
  output logic _4Q,
  output logic _4Q_INV
);

  // Bit n-1 holds stage n.
  logic [3:0] data_in;
  logic [3:0] state_d;
  logic [3:0] state_q;

  assign data_in = {_4D, _3D, _2D, _1D};

  // Clear wins over load; each stage otherwise captures only its own D.
  always_comb begin
    state_d = data_in;
    if (_CLR) begin
      state_d = 4'b0000;
    end
  end

  // NOTE: non-blocking assignment so every stage samples its input at the
  // same edge regardless of evaluation order. The storage has no separate
  // reset; _CLR is the only initialisation, so the state is unknown until
  // the first edge.
  always_ff @(posedge _CLK) begin
    state_q <= state_d;
  end

  // Complements come from the same bits, so Q and Q_INV can never agree.
  assign _1Q     =  state_q[0];
  assign _2Q     =  state_q[1];
  assign _3Q     =  state_q[2];
  assign _4Q     =  state_q[3];
  assign _1Q_INV = ~state_q[0];
  assign _2Q_INV = ~state_q[1];
  assign _3Q_INV = ~state_q[2];
  assign _4Q_INV = ~state_q[3];

endmodule

// File: tb/tb_ls175_quad_dff.sv
// -----------------------------------------------------------------------------
// tb_ls175_quad_dff
//   Self-checking bench for ls175_quad_dff. A table of {clear, D, expected Q}
//   records is applied one edge at a time; expected values go into a
//   scoreboard queue when stimulus is driven and are popped and compared
//   after the edge. Hand-written sequences cover mid-cycle D and clear
//   changes.
// -----------------------------------------------------------------------------
module tb_ls175_quad_dff;

  logic clk;
  logic clr;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] q_inv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       clr;
    logic [3:0] d;
    logic [3:0] exp_q;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] q;
  } exp_t;

  exp_t scoreboard[$];
  vec_t vecs[14];

  ls175_quad_dff dut (
    ._CLK    (clk),
    ._CLR    (clr),
    ._1D     (d[0]),
    ._2D     (d[1]),
    ._3D     (d[2]),
    ._4D     (d[3]),
    ._1Q     (q[0]),
    ._1Q_INV (q_inv[0]),
    ._2Q     (q[1]),
    ._2Q_INV (q_inv[1]),
    ._3Q     (q[2]),
    ._3Q_INV (q_inv[2]),
    ._4Q     (q[3]),
    ._4Q_INV (q_inv[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares both output buses against the expected true value.
  task automatic check(input string name, input logic [3:0] exp_q);
    checks++;
    if (q !== exp_q || q_inv !== ~exp_q) begin
      errors++;
      $display("FAIL %s: q=%b q_inv=%b, expected q=%b q_inv=%b",
               name, q, q_inv, exp_q, ~exp_q);
    end
  endtask

  // Drives one edge's stimulus at the falling edge, records the expectation,
  // then compares just after the rising edge.
  task automatic drive_edge(input string name, input logic c,
                            input logic [3:0] dv, input logic [3:0] exp_q);
    exp_t e;
    @(negedge clk);
    clr = c;
    d   = dv;
    e.name = name;
    e.q    = exp_q;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, expected one entry", name);
    end else begin
      e = scoreboard.pop_front();
      check(e.name, e.q);
    end
  endtask

  initial begin
    clr = 1'b1;
    d   = 4'b1111;

    vecs[0]  = '{"clear",        1'b1, 4'b1111, 4'b0000};
    vecs[1]  = '{"walk1_0001",   1'b0, 4'b0001, 4'b0001};
    vecs[2]  = '{"walk1_0010",   1'b0, 4'b0010, 4'b0010};
    vecs[3]  = '{"walk1_0100",   1'b0, 4'b0100, 4'b0100};
    vecs[4]  = '{"walk1_1000",   1'b0, 4'b1000, 4'b1000};
    vecs[5]  = '{"walk0_1110",   1'b0, 4'b1110, 4'b1110};
    vecs[6]  = '{"walk0_1101",   1'b0, 4'b1101, 4'b1101};
    vecs[7]  = '{"walk0_1011",   1'b0, 4'b1011, 4'b1011};
    vecs[8]  = '{"walk0_0111",   1'b0, 4'b0111, 4'b0111};
    vecs[9]  = '{"load_1111",    1'b0, 4'b1111, 4'b1111};
    vecs[10] = '{"clr_priority", 1'b1, 4'b1111, 4'b0000};
    vecs[11] = '{"clr_release",  1'b0, 4'b1010, 4'b1010};
    vecs[12] = '{"clr_prio_1010",1'b1, 4'b0101, 4'b0000};
    vecs[13] = '{"load_0101",    1'b0, 4'b0101, 4'b0101};

    // First edge with clear applied establishes a known state.
    for (int i = 0; i < 14; i++) begin
      drive_edge(vecs[i].name, vecs[i].clr, vecs[i].d, vecs[i].exp_q);
    end

    // Hold: D toggles entirely between edges; Q must not move until sampled.
    drive_edge("hold_load", 1'b0, 4'b1111, 4'b1111);
    d = 4'b0000;
    #1;
    check("hold_mid_d0", 4'b1111);
    #1;
    d = 4'b1111;
    #1;
    check("hold_mid_d1", 4'b1111);
    drive_edge("hold_edge", 1'b0, 4'b1111, 4'b1111);

    // Clear raised mid-cycle has no effect until the next rising edge.
    clr = 1'b1;
    #1;
    check("sclr_mid", 4'b1111);
    drive_edge("sclr_edge", 1'b1, 4'b1111, 4'b0000);
    drive_edge("sclr_drop", 1'b0, 4'b1111, 4'b1111);

    // Clear pulsed between edges only must be ignored.
    clr = 1'b1;
    #1;
    clr = 1'b0;
    drive_edge("clr_glitch", 1'b0, 4'b1111, 4'b1111);

    if (scoreboard.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0",
               scoreboard.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
